name_sequencer: RTL and testbench
=================================

// Module: name_sequencer
// PURPOSE
//   Upstream driver for the 7-segment letter decoder. Steps a letter index 0..NUM_LETTERS-1
//   at a programmable rate and presents it on 'digit', so the display spells the name one
//   letter at a time. Between runs, and during the end-of-name pause, it drives BLANK_CODE.
//   The decoder consumes 'digit' combinationally; this block owns all timing.
// PARAMETERS
//   TICK_DIV        10_000_000  clk cycles per letter at speed=0 (>=8; 1 s at 10 MHz)
//   NUM_LETTERS     8           letters in the name; digit codes 0..NUM_LETTERS-1 (<=15)
//   END_PAUSE_TICKS 2           blank ticks after the last letter before loop/finish (>=1)
//   BLANK_CODE      4'hF        digit code the decoder renders as all segments off
// PORTS
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   ena        in   1  global enable; low freezes prescaler, state and outputs
//   start      in   1  one-cycle pulse: begin a run (ignored while busy)
//   stop       in   1  synchronous abort to IDLE (priority over start and tick)
//   loop       in   1  level: after the end pause, restart at letter 0 instead of finishing
//   speed      in   2  rate select: tick period = TICK_DIV >> speed cycles
//   digit      out  4  letter code to the decoder (registered)
//   busy       out  1  high in any state other than IDLE
//   done       out  1  one-cycle pulse when a non-looping run returns to IDLE
// BEHAVIOUR
//   Reset: state=IDLE, idx=0, prescaler=0, pause count=0, digit=BLANK_CODE, busy=0, done=0.
//   Prescaler: counts 0..(TICK_DIV>>speed)-1; 'tick' is high for the one cycle at terminal
//     count, then the prescaler wraps to 0. It is cleared on entering SHOW from IDLE and
//     on stop. A speed change takes effect at the next compare; if the count already
//     exceeds the new terminal value, the prescaler wraps to 0 without a tick.
//   States (all transitions only when ena=1):
//     IDLE  digit=BLANK. On start: idx=0 -> SHOW; digit=0 on the next cycle (latency 1).
//     SHOW  digit=idx. On tick: with gap -> GAP; else if idx<NUM_LETTERS-1, idx++ and stay
//           in SHOW; else -> PAUSE.
//     GAP   digit=BLANK for one tick. On tick: if idx<NUM_LETTERS-1, idx++ -> SHOW;
//           else -> PAUSE.
//     PAUSE digit=BLANK for END_PAUSE_TICKS ticks. After the last pause tick: if
//           loop=1, idx=0 -> SHOW; else -> IDLE with done=1 for one cycle.
//   loop is sampled only at PAUSE exit. busy = (state!=IDLE), registered with state.
//   stop in any state: next cycle IDLE, digit=BLANK, idx=0, no done pulse.
//   start and stop in the same cycle: stop wins. start while busy: no effect.
//   ena=0: nothing advances and ticks are not generated; done is held low.
//   Async reset mid-run: immediate return to reset values; no done pulse.
//   idx width is $clog2(NUM_LETTERS); idx never exceeds NUM_LETTERS-1.
// CONFIGURATION
//   NAME_SEQ_GAP_EN defined: SHOW -> GAP -> SHOW, with a one-tick blank between letters
//     so that repeated letters read as separate letters.
//   NAME_SEQ_GAP_EN undefined: GAP is not built. Letters are shown back to back and the
//     last letter goes directly to PAUSE.
// STRUCTURE
//   Shared package name_seq_pkg: state encoding (IDLE, SHOW, GAP, PAUSE), BLANK_CODE
//     default, NUM_LETTERS default. The decoder and the bench use the same constants.
//   Sub-module tick_prescaler: parameter DIV, inputs clk, rst_n, ena, clr, shift[1:0];
//     output tick. The FSM and idx/pause counters live in name_sequencer.
// TESTING  (TICK_DIV=8, NUM_LETTERS=8, END_PAUSE_TICKS=2, speed=0 unless stated)
//   1 Reset: hold rst_n=0, then release -> digit=4'hF, busy=0, done=0; no change for 100 cycles.
//   2 Gap off, start pulse, loop=0 -> digit 0..7 each for 8 cycles, then 16 blank cycles,
//     then done=1 for one cycle and busy=0. Total 81 cycles from start to done.
//   3 Gap on, same stimulus -> 0,F,1,F,...,7,F, each for 8 cycles, then a 16-cycle pause
//     and done. Digit codes 0..7 each appear exactly once.
//   4 loop=1, speed=2 (2-cycle ticks) -> sequence repeats from 0 after the pause; no done
//     pulse. Drop loop to 0 mid-run -> the run ends after the current pause.
//   5 stop asserted during letter 3 -> next cycle IDLE, digit=F, no done pulse. start and
//     stop in the same cycle -> stays IDLE.
//   6 ena=0 for 20 cycles during letter 5 -> digit holds 5 and the prescaler is frozen.
//     After re-enable, letter 5 completes its remaining cycles. Async rst_n pulse mid-run
//     -> reset values in the same cycle.

Source files
------------

// File: rtl/name_seq_pkg.sv
// Shared constants and state encoding for the name sequencer and its decoder.
// Used by rtl/name_sequencer.sv, rtl/tick_prescaler.sv and the bench.
package name_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_GAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    localparam logic [3:0] BLANK_CODE_DEF  = 4'hF;
    localparam int         NUM_LETTERS_DEF = 8;
    localparam int         TICK_DIV_DEF    = 10_000_000;
    localparam int         END_PAUSE_DEF   = 2;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Letter-rate prescaler: one-cycle tick every (DIV >> shift) enabled cycles.
// Frozen while ena is low; clr restarts the count from zero.
module tick_prescaler
    import name_seq_pkg::*;
#(
    parameter int DIV = TICK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       clr,
    input  logic [1:0] shift,
    output logic       tick
);

    localparam int CW = cnt_width(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] term;

    always_comb begin
        term  = CW'((DIV >> shift) - 1);
        tick  = ena && (cnt_q == term);
        cnt_d = cnt_q;
        if (ena) begin
            // Overshoot after a speed-up wraps silently instead of ticking.
            if (clr || (cnt_q >= term)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/name_sequencer.sv
// Steps a letter index at a programmable rate to drive the 7-segment decoder.
// Define NAME_SEQ_GAP_EN to insert a one-tick blank between letters.
module name_sequencer
    import name_seq_pkg::*;
#(
    parameter int         TICK_DIV        = TICK_DIV_DEF,
    parameter int         NUM_LETTERS     = NUM_LETTERS_DEF,
    parameter int         END_PAUSE_TICKS = END_PAUSE_DEF,
    parameter logic [3:0] BLANK_CODE      = BLANK_CODE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic [1:0] speed,
    output logic [3:0] digit,
    output logic       busy,
    output logic       done
);

    localparam int IW = cnt_width(NUM_LETTERS);
    localparam int PW = cnt_width(END_PAUSE_TICKS);

    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_LETTERS - 1);
    localparam logic [PW-1:0] LAST_PAUSE = PW'(END_PAUSE_TICKS - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] pause_q, pause_d;
    logic [3:0]    digit_q, digit_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick;
    logic          clr;
    logic          last_letter;

    tick_prescaler #(
        .DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .clr  (clr),
        .shift(speed),
        .tick (tick)
    );

    assign last_letter = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pause_d = pause_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        if (ena) begin
            if (stop) begin
                state_d = ST_IDLE;
                idx_d   = '0;
                pause_d = '0;
                clr     = 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_d = ST_SHOW;
                            idx_d   = '0;
                            pause_d = '0;
                            clr     = 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        if (tick) begin
`ifdef NAME_SEQ_GAP_EN
                            state_d = ST_GAP;
`else
                            if (!last_letter) begin
                                idx_d = idx_q + IW'(1);
                            end else begin
                                state_d = ST_PAUSE;
                                pause_d = '0;
                            end
`endif
                        end
                    end
`ifdef NAME_SEQ_GAP_EN
                    ST_GAP: begin
                        if (tick) begin
                            if (!last_letter) begin
                                state_d = ST_SHOW;
                                idx_d   = idx_q + IW'(1);
                            end else begin
                                state_d = ST_PAUSE;
                                pause_d = '0;
                            end
                        end
                    end
`endif
                    ST_PAUSE: begin
                        if (tick) begin
                            if (pause_q != LAST_PAUSE) begin
                                pause_d = pause_q + PW'(1);
                            end else if (loop) begin
                                state_d = ST_SHOW;
                                idx_d   = '0;
                                pause_d = '0;
                            end else begin
                                state_d = ST_IDLE;
                                idx_d   = '0;
                                pause_d = '0;
                                done_d  = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        pause_d = '0;
                    end
                endcase
            end
        end
        // Outputs are registered from the next state so they line up with it.
        digit_d = (state_d == ST_SHOW) ? 4'(idx_d) : BLANK_CODE;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pause_q <= '0;
            digit_q <= BLANK_CODE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pause_q <= pause_d;
            digit_q <= digit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign digit = digit_q;
    assign busy  = busy_q;
    assign done  = done_q & ena;

endmodule

// File: tb/tb_name_sequencer.sv
// Self-checking bench for name_sequencer: directed scenarios plus random
// stimulus against a timeline model (elapsed enabled cycles since run start).
module tb_name_sequencer;
    import name_seq_pkg::*;

    localparam int TICK_DIV = 8;
    localparam int NUM      = 8;
    localparam int PAUSE_T  = 2;
`ifdef NAME_SEQ_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif
    localparam int SLOTS     = NUM * (GAP ? 2 : 1);
    localparam int RUN_EDGES = (SLOTS + PAUSE_T) * TICK_DIV + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [3:0] digit;
    logic       busy;
    logic       done;

    int  ncmp = 0;
    int  nfail = 0;
    bit  m_run = 1'b0;
    int  m_e = 0;
    bit  m_done = 1'b0;

    name_sequencer #(
        .TICK_DIV       (TICK_DIV),
        .NUM_LETTERS    (NUM),
        .END_PAUSE_TICKS(PAUSE_T),
        .BLANK_CODE     (4'hF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .start(start),
        .stop (stop),
        .loop (loop),
        .speed(speed),
        .digit(digit),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // Expected {digit, busy, done} from the elapsed-time position in the run.
    function automatic logic [5:0] exp_out();
        logic [3:0] d;
        int p;
        int slot;
        p = TICK_DIV >> speed;
        d = 4'hF;
        if (m_run) begin
            slot = m_e / p;
            if (slot < SLOTS) begin
                if (GAP) d = (slot % 2 != 0) ? 4'hF : 4'(slot / 2);
                else     d = 4'(slot);
            end
        end
        return {d, m_run, m_done & ena};
    endfunction

    task automatic model_edge(input logic st, sp, en, lp,
                              input logic [1:0] spd);
        int p;
        p = TICK_DIV >> spd;
        m_done = 1'b0;
        if (en) begin
            if (sp) begin
                m_run = 1'b0;
                m_e   = 0;
            end else if (!m_run) begin
                if (st) begin
                    m_run = 1'b1;
                    m_e   = 0;
                end
            end else begin
                m_e++;
                if (m_e == (SLOTS + PAUSE_T) * p) begin
                    if (lp) begin
                        m_e = 0;
                    end else begin
                        m_run  = 1'b0;
                        m_e    = 0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic drive(input logic st, sp, en, lp,
                         input logic [1:0] spd);
        start = st;
        stop  = sp;
        ena   = en;
        loop  = lp;
        speed = spd;
        @(posedge clk);
        model_edge(st, sp, en, lp, spd);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        ncmp++;
        if ({digit, busy, done} !== {4'hF, 1'b0, 1'b0}) begin
            nfail++;
            $display("FAIL reset_hold got=%h/%b/%b exp=f/0/0",
                     digit, busy, done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
            ncmp++;
            if ({digit, busy, done} !== {4'hF, 1'b0, 1'b0}) begin
                nfail++;
                $display("FAIL reset_idle cyc=%0d got=%h/%b/%b exp=f/0/0",
                         i, digit, busy, done);
            end
        end
    endtask

    task automatic test_run_once();
        logic [3:0] seq[$];
        logic [3:0] want[$];
        int edges;
        bit seq_ok;
        for (int i = 0; i < NUM; i++) begin
            want.push_back(4'(i));
            if (GAP && i < NUM - 1) want.push_back(4'hF);
        end
        want.push_back(4'hF);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        edges = 1;
        seq.push_back(digit);
        while (done !== 1'b1 && edges < 400) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
            edges++;
            ncmp++;
            if ({digit, busy, done} !== exp_out()) begin
                nfail++;
                $display("FAIL run_once t=%0t got=%h/%b/%b exp=%h",
                         $time, digit, busy, done, exp_out());
            end
            if (digit !== seq[$]) seq.push_back(digit);
        end
        ncmp++;
        if (edges != RUN_EDGES) begin
            nfail++;
            $display("FAIL run_latency got=%0d exp=%0d", edges, RUN_EDGES);
        end
        seq_ok = (seq.size() == want.size());
        if (seq_ok) begin
            for (int i = 0; i < want.size(); i++)
                if (seq[i] !== want[i]) seq_ok = 1'b0;
        end
        ncmp++;
        if (!seq_ok) begin
            nfail++;
            $display("FAIL run_sequence got_len=%0d exp_len=%0d",
                     seq.size(), want.size());
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        ncmp++;
        if ({digit, busy, done} !== {4'hF, 1'b0, 1'b0}) begin
            nfail++;
            $display("FAIL done_one_cycle got=%h/%b/%b exp=f/0/0",
                     digit, busy, done);
        end
    endtask

    task automatic test_loop();
        int dones;
        int restarts;
        int cyc;
        logic [3:0] prev;
        dones = 0;
        restarts = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd2);
        prev = digit;
        for (int i = 0; i < 3 * (SLOTS + PAUSE_T) * 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd2);
            ncmp++;
            if ({digit, busy, done} !== exp_out()) begin
                nfail++;
                $display("FAIL loop_run t=%0t got=%h/%b/%b exp=%h",
                         $time, digit, busy, done, exp_out());
            end
            if (done === 1'b1) dones++;
            if (prev === 4'hF && digit === 4'h0) restarts++;
            prev = digit;
        end
        ncmp++;
        if (dones != 0 || restarts != 3) begin
            nfail++;
            $display("FAIL loop_restart dones=%0d restarts=%0d exp=0/3",
                     dones, restarts);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
            cyc++;
            ncmp++;
            if ({digit, busy, done} !== exp_out()) begin
                nfail++;
                $display("FAIL loop_drain t=%0t got=%h/%b/%b exp=%h",
                         $time, digit, busy, done, exp_out());
            end
            if (done === 1'b1) dones++;
        end
        ncmp++;
        if (cyc != (SLOTS + PAUSE_T) * 2 || dones != 1) begin
            nfail++;
            $display("FAIL loop_exit cycles=%0d dones=%0d exp=%0d/1",
                     cyc, dones, (SLOTS + PAUSE_T) * 2);
        end
    endtask

    task automatic test_stop();
        int guard;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        guard = 0;
        while (m_e < 3 * TICK_DIV * (GAP ? 2 : 1) + 2 && guard < 200) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
            guard++;
        end
        ncmp++;
        if (digit !== 4'h3) begin
            nfail++;
            $display("FAIL stop_before got=%h exp=3", digit);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        ncmp++;
        if ({digit, busy, done} !== {4'hF, 1'b0, 1'b0}) begin
            nfail++;
            $display("FAIL stop_abort got=%h/%b/%b exp=f/0/0",
                     digit, busy, done);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
            ncmp++;
            if ({digit, busy, done} !== exp_out()) begin
                nfail++;
                $display("FAIL stop_idle cyc=%0d got=%h/%b/%b exp=%h",
                         i, digit, busy, done, exp_out());
            end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        ncmp++;
        if ({digit, busy, done} !== {4'hF, 1'b0, 1'b0}) begin
            nfail++;
            $display("FAIL start_stop got=%h/%b/%b exp=f/0/0",
                     digit, busy, done);
        end
    endtask

    task automatic test_ena_freeze();
        int fives;
        int guard;
        fives = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        guard = 0;
        while (m_e < 5 * TICK_DIV * (GAP ? 2 : 1) + 3 && guard < 200) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
            if (digit === 4'h5) fives++;
            guard++;
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
            if (digit === 4'h5) fives++;
            ncmp++;
            if ({digit, busy, done} !== {4'h5, 1'b1, 1'b0}) begin
                nfail++;
                $display("FAIL ena_freeze cyc=%0d got=%h/%b/%b exp=5/1/0",
                         i, digit, busy, done);
            end
        end
        guard = 0;
        while (busy === 1'b1 && guard < 400) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
            if (digit === 4'h5) fives++;
            guard++;
            ncmp++;
            if ({digit, busy, done} !== exp_out()) begin
                nfail++;
                $display("FAIL ena_resume t=%0t got=%h/%b/%b exp=%h",
                         $time, digit, busy, done, exp_out());
            end
        end
        ncmp++;
        if (fives != TICK_DIV + 20) begin
            nfail++;
            $display("FAIL ena_letter5 cycles=%0d exp=%0d",
                     fives, TICK_DIV + 20);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        repeat (30) drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        ncmp++;
        if ({digit, busy, done} !== {4'hF, 1'b0, 1'b0}) begin
            nfail++;
            $display("FAIL async_reset got=%h/%b/%b exp=f/0/0",
                     digit, busy, done);
        end
        m_run = 1'b0;
        m_e = 0;
        m_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
            ncmp++;
            if ({digit, busy, done} !== {4'hF, 1'b0, 1'b0}) begin
                nfail++;
                $display("FAIL async_after cyc=%0d got=%h/%b/%b exp=f/0/0",
                         i, digit, busy, done);
            end
        end
    endtask

    task automatic test_random();
        logic st, sp, en, lp;
        logic [1:0] spd;
        lp = 1'b0;
        spd = 2'd0;
        for (int i = 0; i < 5000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) lp = ~lp;
            if (!m_run && $urandom_range(0, 3) == 0)
                spd = 2'($urandom_range(0, 3));
            drive(st, sp, en, lp, spd);
            ncmp++;
            if ({digit, busy, done} !== exp_out()) begin
                nfail++;
                $display("FAIL random cyc=%0d got=%h/%b/%b exp=%h",
                         i, digit, busy, done, exp_out());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_run_once();
        test_loop();
        test_stop();
        test_ena_freeze();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
